result_bcd_converter: RTL
=========================

# result_bcd_converter

Sequential signed-binary-to-BCD converter sitting directly downstream of the division (and other arithmetic) blocks of the calculator datapath. It captures an 8-bit two's-complement result on a one-cycle valid strobe (wired from `done_division`), converts its magnitude to three BCD digits with an iterative shift-add-3 (double-dabble) engine, and presents sign, digits and leading-zero blanking flags to the display stage with a one-cycle `done` pulse.

## Interface
Parameters:
- none; widths are fixed (8-bit input, 3 BCD digits).

Ports:
- `clk` input 1 — single clock; all state changes on rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `result` input 8 — signed two's-complement value to convert; sampled only on the accepting edge.
- `result_valid` input 1 — one-cycle strobe; connect to the producer's done pulse.
- `clear` input 1 — synchronous clear of the display outputs.
- `neg` output 1 — 1 when the captured value was negative.
- `hundreds` output 4 — BCD hundreds digit (0 or 1).
- `tens` output 4 — BCD tens digit.
- `ones` output 4 — BCD ones digit.
- `blank_h` output 1 — hundreds digit is a leading zero.
- `blank_t` output 1 — hundreds and tens are both leading zeros.
- `busy` output 1 — conversion in progress.
- `done` output 1 — one-cycle pulse when new outputs are valid.

## Operation
- States: IDLE, CONVERT. Reset and `clear` do not add states.
- IDLE: on an edge with `result_valid`=1 (and `clear`=0): capture `neg`-pending = `result[7]`; magnitude = `result[7]` ? (~result + 1) : result, held as 8-bit unsigned (0x80 → 128, no overflow); load 20-bit shift register {12'b0, magnitude}; iteration counter = 0; go to CONVERT.
- CONVERT, each edge: for each of the three 4-bit BCD nibbles, add 3 if nibble ≥ 5; then shift the whole 20-bit register left by one; counter + 1.
- On the edge performing iteration 8 (counter 7 → 8): write `hundreds`/`tens`/`ones` from the post-shift register, write `neg`, compute blanking, assert `done` for that cycle, return to IDLE.
- Blanking: `blank_h` = (hundreds == 0); `blank_t` = `blank_h` & (tens == 0). `ones` is never blanked (zero shows "0").
- Outputs hold the last completed conversion until the next `done` or `clear`.
- `result_valid` while in CONVERT is ignored (no queue, no error flag); producers must not strobe faster than once per 9 cycles.
- `clear`=1 at an edge: display outputs go to reset values; if in CONVERT, conversion is aborted, state → IDLE, no `done`. `clear` has priority over `result_valid`.

## Timing
- Reset values: `neg`=0, `hundreds`=`tens`=`ones`=0, `blank_h`=1, `blank_t`=1, `busy`=0, `done`=0, state IDLE, counter 0.
- `rst` asserted mid-conversion: immediate abort to reset values; no `done` after release.
- Latency: `result_valid` sampled at edge E0 → `busy`=1 after E0 → `done`=1 and new outputs after E8 (8 cycles) → `busy`=0 after E8.
- `busy` = (state == CONVERT); high for exactly 8 cycles per conversion.
- `result_valid` in the cycle where `done`=1 is accepted (state is IDLE then); throughput one result per 9 cycles.
- `done` never high in two consecutive cycles.
- Arithmetic: digits are always legal BCD (0–9); hundreds ≤ 1 for all inputs.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs at reset values immediately; `blank_h`=`blank_t`=1, `ones`=0.
- Positive: `result`=0x05 strobe → after 8 cycles `done`=1, neg=0, digits 0/0/5, blank_h=1, blank_t=1; `result`=0x7F → 1/2/7, neg=0, no blanking.
- Negative from divider: `result`=0xFE (−2) → neg=1, 0/0/2, blank_t=1; `result`=0xF9 (−7) → neg=1, 0/0/7.
- Boundary: `result`=0x80 → neg=1, 1/2/8, blank_h=0; `result`=0x00 → neg=0, 0/0/0, blank_t=1.
- Back-to-back: strobe 0x0A, strobe 0x03 three cycles later (ignored), strobe 0x63 in the `done` cycle → first done shows 0/1/0, second done exactly 8 cycles later shows 0/9/9; 0x03 never appears.
- Abort: strobe 0x64, pulse `rst` (then separately `clear`) at cycle 4 → no `done`, outputs at reset values; next strobe 0x15 converts to 0/2/1 normally.

Source files
------------

// File: rtl/result_bcd_converter.sv
// Signed 8-bit result to sign + three BCD digits using an iterative double-dabble engine.
// One conversion takes 8 cycles. Outputs hold the last completed conversion and are blanked for the display.
module result_bcd_converter (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] result,
  input  logic       result_valid,
  input  logic       clear,
  output logic       neg,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       blank_h,
  output logic       blank_t,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t      state;
  logic [3:0]  iter;
  logic [19:0] shreg;
  logic        neg_pend;

  logic [7:0]  mag;
  logic [19:0] adj;
  logic [19:0] shifted;

  // 0x80 negates to 0x80, which reads as 128 when taken as unsigned.
  always_comb begin
    mag = result[7] ? (~result + 8'd1) : result;
  end

  always_comb begin
    adj = shreg;
    for (int unsigned i = 0; i < 3; i++) begin
      if (shreg[8 + 4*i +: 4] >= 4'd5)
        adj[8 + 4*i +: 4] = shreg[8 + 4*i +: 4] + 4'd3;
    end
    shifted = adj << 1;
  end

  assign busy = (state == CONVERT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      iter     <= '0;
      shreg    <= '0;
      neg_pend <= 1'b0;
      neg      <= 1'b0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
      blank_h  <= 1'b1;
      blank_t  <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state    <= IDLE;
        iter     <= '0;
        neg      <= 1'b0;
        hundreds <= '0;
        tens     <= '0;
        ones     <= '0;
        blank_h  <= 1'b1;
        blank_t  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (result_valid) begin
              neg_pend <= result[7];
              shreg    <= {12'b0, mag};
              iter     <= '0;
              state    <= CONVERT;
            end
          end
          CONVERT: begin
            shreg <= shifted;
            iter  <= iter + 4'd1;
            if (iter == 4'd7) begin
              hundreds <= shifted[19:16];
              tens     <= shifted[15:12];
              ones     <= shifted[11:8];
              blank_h  <= (shifted[19:16] == 4'd0);
              blank_t  <= (shifted[19:16] == 4'd0) && (shifted[15:12] == 4'd0);
              neg      <= neg_pend;
              done     <= 1'b1;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
